// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Holds FSM states, instruction classes, opcode fields and control encodings.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CL_ALU    = 2'd0,
    CL_LOAD   = 2'd1,
    CL_STORE  = 2'd2,
    CL_BRANCH = 2'd3
  } insn_class_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_CMP = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction- and data-memory request/acknowledge bundle.
// Handshake: a req stays high until the cycle its ack is high; that cycle completes the transfer
// (imem_rdata is valid with imem_ack). An ack seen while the matching req is low carries no meaning.
interface multicycle_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational RV32I subset decoder: classifies the instruction register and
// produces the ALU/immediate selects; anything outside the subset is flagged illegal.
module insn_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output insn_class_t cls,
  output logic        is_bne,
  output logic [1:0]  alu_ctrl,
  output logic        alu_src,
  output logic [1:0]  imm_src,
  output logic        illegal
);

  always_comb begin
    cls      = CL_ALU;
    alu_ctrl = ALU_ADD;
    alu_src  = 1'b0;
    imm_src  = IMM_I;
    illegal  = 1'b1;
    is_bne   = (funct3 == F3_BNE);
    case (opcode)
      OP_IMM: begin
        alu_src = 1'b1;
        illegal = (funct3 != F3_ADD);
      end
      OP_REG: begin
        alu_ctrl = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        illegal  = (funct3 != F3_ADD) || ((funct7 != F7_ADD) && (funct7 != F7_SUB));
      end
      OP_LOAD: begin
        cls     = CL_LOAD;
        alu_src = 1'b1;
        illegal = (funct3 != F3_LW);
      end
      OP_STORE: begin
        cls     = CL_STORE;
        alu_src = 1'b1;
        imm_src = IMM_S;
        illegal = (funct3 != F3_SW);
      end
      OP_BRANCH: begin
        cls      = CL_BRANCH;
        alu_ctrl = ALU_CMP;
        imm_src  = IMM_B;
        illegal  = (funct3 != F3_BEQ) && (funct3 != F3_BNE);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetches into IR, then steps FETCH/DECODE/EXEC/MEM/WB
// and pulses the datapath strobes; illegal encodings park the FSM in TRAP until reset.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_ctrl_if.master        mem,
  input  logic                     EQ,
  output logic                     PCen,
  output logic                     PCsrc,
  output logic                     RegWrite,
  output logic                     ALUsrc,
  output logic [1:0]               ALUctrl,
  output logic                     ResultSrc,
  output logic [1:0]               ImmSrc,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic                     illegal,
  output logic [DATA_WIDTH-1:0]    retired,
  output state_t                   state
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] retired_q;

  insn_class_t dec_cls;
  logic        dec_bne, dec_alusrc, dec_illegal;
  logic [1:0]  dec_aluctrl, dec_immsrc;

  logic load_ir, retire;
  logic imem_req_c, dmem_req_c, pcen_c, regwrite_c;

  insn_decoder u_dec (
    .opcode   (ir_q[6:0]),
    .funct3   (ir_q[14:12]),
    .funct7   (ir_q[31:25]),
    .cls      (dec_cls),
    .is_bne   (dec_bne),
    .alu_ctrl (dec_aluctrl),
    .alu_src  (dec_alusrc),
    .imm_src  (dec_immsrc),
    .illegal  (dec_illegal)
  );

  assign rs1 = ir_q[15 +: ADDRESS_WIDTH];
  assign rs2 = ir_q[20 +: ADDRESS_WIDTH];
  assign rd  = ir_q[7 +: ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_ir) ir_q <= mem.imem_rdata;
      if (retire)  retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_ir    = 1'b0;
    retire     = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    mem.dmem_we = 1'b0;
    pcen_c     = 1'b0;
    PCsrc      = 1'b0;
    regwrite_c = 1'b0;
    ALUsrc     = 1'b0;
    ALUctrl    = ALU_ADD;
    ResultSrc  = 1'b0;
    ImmSrc     = IMM_I;
    case (state_q)
      FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          load_ir = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUsrc  = dec_alusrc;
        ALUctrl = dec_aluctrl;
        ImmSrc  = dec_immsrc;
        state_d = dec_illegal ? TRAP : EXEC;
      end
      EXEC: begin
        ALUsrc  = dec_alusrc;
        ALUctrl = dec_aluctrl;
        ImmSrc  = dec_immsrc;
        case (dec_cls)
          CL_BRANCH: begin
            // BNE takes the branch on !EQ, BEQ on EQ.
            pcen_c  = 1'b1;
            PCsrc   = EQ ^ dec_bne;
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          default:           state_d = WB;
        endcase
      end
      MEM: begin
        ImmSrc      = dec_immsrc;
        dmem_req_c  = 1'b1;
        mem.dmem_we = (dec_cls == CL_STORE);
        if (mem.dmem_ack) begin
          if (dec_cls == CL_STORE) begin
            pcen_c  = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        ImmSrc     = dec_immsrc;
        regwrite_c = (rd != '0);
        ResultSrc  = (dec_cls == CL_LOAD);
        pcen_c     = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Strobes are forced low for the whole time reset is held, whatever state is registered.
  assign mem.imem_req = rst & imem_req_c;
  assign mem.dmem_req = rst & dmem_req_c;
  assign PCen         = rst & pcen_c;
  assign RegWrite     = rst & regwrite_c;

  assign illegal = (state_q == TRAP);
  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of instructions with hand-computed control
// expectations, plus reset-in-MEM, trap, spurious-ack and retired-wrap sequences.
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EQ = 1'b0;
  logic        PCen, PCsrc, RegWrite, ALUsrc, ResultSrc, illegal;
  logic [1:0]  ALUctrl, ImmSrc;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] retired;
  state_t      state;

  multicycle_ctrl_if #(.DATA_WIDTH(32)) mif ();

  multicycle_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .mem(mif), .EQ(EQ),
    .PCen(PCen), .PCsrc(PCsrc), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal), .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic        eq;
    int          iw;
    int          dw;
    logic        spur;
    int          cyc;
    logic        pcsrc;
    int          rw;
    logic        rsrc;
    int          rd;
    int          dreq;
    logic        we;
    logic        alusrc;
    logic [1:0]  aluctrl;
    logic [1:0]  immsrc;
  } vec_t;

  typedef struct {
    int         cyc;
    int         pcen;
    logic       pcsrc;
    int         rw;
    logic       rsrc;
    int         rd;
    int         dreq;
    logic       we;
    logic       alusrc;
    logic [1:0] aluctrl;
    logic [1:0] immsrc;
    int         both;
    logic       done;
  } obs_t;

  function automatic vec_t mk(input string n, input logic [31:0] insn, input logic eq,
                              input int iw, input int dw, input logic spur, input int cyc,
                              input logic pcsrc, input int rw, input logic rsrc, input int rdv,
                              input int dreq, input logic we, input logic alusrc,
                              input logic [1:0] aluctrl, input logic [1:0] immsrc);
    vec_t v;
    v.name = n; v.insn = insn; v.eq = eq; v.iw = iw; v.dw = dw; v.spur = spur;
    v.cyc = cyc; v.pcsrc = pcsrc; v.rw = rw; v.rsrc = rsrc; v.rd = rdv; v.dreq = dreq;
    v.we = we; v.alusrc = alusrc; v.aluctrl = aluctrl; v.immsrc = immsrc;
    return v;
  endfunction

  // Memory responder for one instruction: acks after iw/dw wait cycles, optional junk acks
  // while no request is pending. Ends one cycle after the PCen pulse, or after bound cycles.
  task automatic run_insn(input logic [31:0] insn, input logic eq, input int iw, input int dw,
                          input logic spur, input int bound, output obs_t o);
    int iwait = iw;
    int dwait = dw;
    int dec_c = -1;
    o = '{default: 0};
    EQ = eq;
    for (int c = 0; c < bound && !o.done; c++) begin
      @(negedge clk);
      mif.imem_rdata = 32'h0;
      mif.imem_ack   = spur;
      mif.dmem_ack   = spur;
      if (mif.imem_req) begin
        mif.imem_rdata = insn;
        mif.imem_ack   = (iwait == 0);
        if (iwait == 0) dec_c = c + 1;
        else iwait--;
      end
      if (mif.dmem_req) begin
        o.dreq++;
        o.we = mif.dmem_we;
        mif.dmem_ack = (dwait == 0);
        if (dwait > 0) dwait--;
      end
      #1;
      if (mif.imem_req && mif.dmem_req) o.both++;
      if (c == dec_c) begin
        o.alusrc  = ALUsrc;
        o.aluctrl = ALUctrl;
        o.immsrc  = ImmSrc;
      end
      if (RegWrite) begin
        o.rw++;
        o.rsrc = ResultSrc;
        o.rd   = int'(rd);
      end
      if (PCen) begin
        o.pcen++;
        o.pcsrc = PCsrc;
        o.cyc   = c + 1;
        o.done  = 1'b1;
      end
    end
    @(negedge clk);
    mif.imem_ack   = 1'b0;
    mif.dmem_ack   = 1'b0;
    mif.imem_rdata = 32'h0;
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {mif.imem_req, mif.dmem_req, PCen, RegWrite};
  endfunction

  vec_t        vecs[$];
  obs_t        o;
  logic [31:0] exp_retired;
  logic [31:0] ill_list[$];
  int          bad;

  initial begin
    mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; mif.imem_rdata = 32'h0;

    //             name          insn          eq iw dw sp cyc pcs rw rs rd dq we as alu    imm
    vecs.push_back(mk("addi",      32'h00500513, 0, 0, 0, 0, 4, 0, 1, 0, 10, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk("bne_ne",    32'hFE051EE3, 0, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk("bne_eq",    32'hFE051EE3, 1, 0, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk("beq_eq",    32'h00208463, 1, 0, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk("beq_ne_w",  32'h00208463, 0, 2, 0, 0, 5, 0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10));
    vecs.push_back(mk("lw_w3",     32'h00052283, 0, 0, 3, 0, 8, 0, 1, 1, 5,  4, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk("sw",        32'h00552223, 0, 0, 0, 0, 4, 0, 0, 0, 0,  1, 1, 1, 2'b00, 2'b01));
    vecs.push_back(mk("sw_w",      32'h00552223, 0, 1, 2, 0, 7, 0, 0, 0, 0,  3, 1, 1, 2'b00, 2'b01));
    vecs.push_back(mk("add_w",     32'h002081B3, 0, 1, 0, 0, 5, 0, 1, 0, 3,  0, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk("sub",       32'h402081B3, 0, 0, 0, 0, 4, 0, 1, 0, 3,  0, 0, 0, 2'b01, 2'b00));
    vecs.push_back(mk("addi_x0",   32'h00000013, 0, 0, 0, 0, 4, 0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk("addi_spur", 32'h00500513, 0, 0, 0, 1, 4, 0, 1, 0, 10, 0, 0, 1, 2'b00, 2'b00));
    vecs.push_back(mk("lw_spur",   32'h00052283, 0, 0, 2, 1, 7, 0, 1, 1, 5,  3, 0, 1, 2'b00, 2'b00));

    // Power-up reset
    repeat (3) @(negedge clk);
    #1;
    chk("reset_strobes", 32'(strobes()), 32'h0);
    chk("reset_retired", retired, 32'h0);
    chk("reset_illegal", 32'(illegal), 32'h0);
    chk("reset_state", 32'(state), 32'(FETCH));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release_imem_req", 32'(mif.imem_req), 32'h1);
    exp_retired = 32'h0;

    foreach (vecs[i]) begin
      run_insn(vecs[i].insn, vecs[i].eq, vecs[i].iw, vecs[i].dw, vecs[i].spur, 40, o);
      exp_retired = exp_retired + 32'h1;
      chk({vecs[i].name, "_cycles"},  o.cyc,       vecs[i].cyc);
      chk({vecs[i].name, "_pcen"},    o.pcen,      1);
      chk({vecs[i].name, "_pcsrc"},   32'(o.pcsrc), 32'(vecs[i].pcsrc));
      chk({vecs[i].name, "_regw"},    o.rw,        vecs[i].rw);
      chk({vecs[i].name, "_ressrc"},  32'(o.rsrc), 32'(vecs[i].rsrc));
      chk({vecs[i].name, "_rd"},      o.rd,        vecs[i].rd);
      chk({vecs[i].name, "_dreq"},    o.dreq,      vecs[i].dreq);
      chk({vecs[i].name, "_we"},      32'(o.we),   32'(vecs[i].we));
      chk({vecs[i].name, "_alusrc"},  32'(o.alusrc), 32'(vecs[i].alusrc));
      chk({vecs[i].name, "_aluctrl"}, 32'(o.aluctrl), 32'(vecs[i].aluctrl));
      chk({vecs[i].name, "_immsrc"},  32'(o.immsrc), 32'(vecs[i].immsrc));
      chk({vecs[i].name, "_both"},    o.both,      0);
      chk({vecs[i].name, "_retired"}, retired,     exp_retired);
    end

    // Reset held for 3 cycles in the middle of a load's MEM wait
    @(negedge clk);
    mif.imem_ack = mif.imem_req; mif.imem_rdata = 32'h00052283;
    @(negedge clk);
    mif.imem_ack = 1'b0; mif.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("midmem_dmem_req", 32'(mif.dmem_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("midmem_rst_gate", 32'(strobes()), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("midmem_rst_strobes", 32'(strobes()), 32'h0);
      chk("midmem_rst_retired", retired, 32'h0);
    end
    chk("midmem_rst_state", 32'(state), 32'(FETCH));
    rst = 1'b1;
    #1;
    chk("midmem_release_req", 32'(strobes()), 32'h8);
    mif.dmem_ack = 1'b1;
    @(negedge clk);
    mif.dmem_ack = 1'b0;
    #1;
    chk("late_dmem_ack_ignored", 32'(state), 32'(FETCH));
    chk("late_dmem_ack_retired", retired, 32'h0);

    // Illegal encodings park in TRAP until reset
    ill_list = '{32'h00000000, 32'h00001013, 32'h0020C1B3, 32'h022081B3, 32'h00002463, 32'h00051283};
    foreach (ill_list[j]) begin
      run_insn(ill_list[j], 1'b0, 0, 0, 1'b0, 8, o);
      chk("trap_no_pcen", o.pcen, 0);
      chk("trap_no_regw", o.rw, 0);
      chk("trap_illegal", 32'(illegal), 32'h1);
      chk("trap_state", 32'(state), 32'(TRAP));
      if (j == 0) begin
        bad = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          mif.imem_ack   = 1'($urandom_range(0, 1));
          mif.dmem_ack   = 1'($urandom_range(0, 1));
          mif.imem_rdata = $urandom;
          #1;
          if (strobes() != 4'h0 || !illegal) bad++;
        end
        mif.imem_ack = 1'b0; mif.dmem_ack = 1'b0; mif.imem_rdata = 32'h0;
        chk("trap_random_acks", bad, 0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("trap_cleared", 32'(illegal), 32'h0);
      chk("trap_cleared_state", 32'(state), 32'(FETCH));
    end

    // retired wraps from all-ones to zero
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    #1;
    chk("wrap_preload", retired, 32'hFFFF_FFFF);
    run_insn(32'h00500513, 1'b0, 0, 0, 1'b0, 40, o);
    chk("wrap_pcen", o.pcen, 1);
    chk("wrap_retired", retired, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
